mips_registers_bank: RTL and testbench



---
 rtl/mips_registers_bank.sv | 43 ++++
 tb/tb_mips_registers_bank.sv | 108 ++++++++++
 2 files changed

// File: rtl/mips_registers_bank.sv
// mips_registers_bank: 32x32 MIPS register file, two registered read ports with write-first forwarding,
// port A switchable to a zero-latency path for JR/JALR targets.
module mips_registers_bank #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 5,
  parameter int BANK_DEPTH = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_reg_write,
  input  logic               i_jr_jalr,
  input  logic [NB_ADDR-1:0] i_read_reg_a,
  input  logic [NB_ADDR-1:0] i_read_reg_b,
  input  logic [NB_ADDR-1:0] i_write_reg,
  input  logic [NB_DATA-1:0] i_write_data,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b
);
  logic [NB_DATA-1:0] regs_q [BANK_DEPTH];
  logic [NB_DATA-1:0] data_a_q, data_b_q, data_a_d, data_b_d;
  logic               wr_en;
  // R0 is never stored to, so a read of address 0 is forced to zero regardless of any write.
  assign wr_en = i_reset && i_reg_write && (i_write_reg != '0);
  always_comb begin
    data_a_d = (i_read_reg_a == '0) ? '0 :
               (wr_en && i_write_reg == i_read_reg_a) ? i_write_data : regs_q[i_read_reg_a];
    data_b_d = (i_read_reg_b == '0) ? '0 :
               (wr_en && i_write_reg == i_read_reg_b) ? i_write_data : regs_q[i_read_reg_b];
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int i = 0; i < BANK_DEPTH; i++) regs_q[i] <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      if (wr_en) regs_q[i_write_reg] <= i_write_data;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end
  assign o_data_a = i_jr_jalr ? data_a_d : data_a_q;
  assign o_data_b = data_b_q;
endmodule

// File: tb/tb_mips_registers_bank.sv
// tb_mips_registers_bank: directed self-checking bench for the register file.
module tb_mips_registers_bank;
  logic        clk = 1'b0;
  logic        rst_n, we, jr;
  logic [4:0]  ra, rb, wr;
  logic [31:0] wd, da, db;
  int          checks = 0;
  int          failures = 0;
  mips_registers_bank dut (
    .i_clock(clk), .i_reset(rst_n), .i_reg_write(we), .i_jr_jalr(jr),
    .i_read_reg_a(ra), .i_read_reg_b(rb), .i_write_reg(wr), .i_write_data(wd),
    .o_data_a(da), .o_data_b(db)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; we = 1'b0; jr = 1'b0; ra = '0; rb = '0; wr = '0; wd = '0;
    repeat (2) @(posedge clk);
    step();
    check("reset_a", da, 32'd0);
    check("reset_b", db, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i);
      step();
      check($sformatf("rst_read_a_r%0d", i), da, 32'd0);
      check($sformatf("rst_read_b_r%0d", 31 - i), db, 32'd0);
    end
    we = 1'b1; wr = 5'd10; wd = 32'd99; ra = 5'd0; rb = 5'd0;
    step();
    we = 1'b0; ra = 5'd10; rb = 5'd0;
    step();
    check("wr_rd_a_r10", da, 32'd99);
    check("wr_rd_b_r0", db, 32'd0);
    we = 1'b1; wr = 5'd1; wd = 32'd555;
    step();
    wr = 5'd31; wd = 32'd111;
    step();
    we = 1'b0; ra = 5'd1; rb = 5'd0;
    step();
    check("multi_a_r1", da, 32'd555);
    check("multi_b_r0", db, 32'd0);
    rb = 5'd31;
    step();
    check("multi_b_r31", db, 32'd111);
    check("multi_a_r1_hold", da, 32'd555);
    we = 1'b1; wr = 5'd0; wd = 32'hDEADBEEF; ra = 5'd0; rb = 5'd0;
    step();
    check("r0_same_edge_a", da, 32'd0);
    check("r0_same_edge_b", db, 32'd0);
    we = 1'b0;
    step();
    check("r0_after_a", da, 32'd0);
    check("r0_after_b", db, 32'd0);
    we = 1'b1; wr = 5'd5; wd = 32'h0000_1234; ra = 5'd5; rb = 5'd5;
    step();
    check("fwd_a_r5", da, 32'h0000_1234);
    check("fwd_b_r5", db, 32'h0000_1234);
    we = 1'b0; wr = 5'd6; wd = 32'hCAFE_F00D; ra = 5'd6; rb = 5'd10;
    step();
    check("nofwd_a_r6", da, 32'd0);
    check("nofwd_b_r10", db, 32'd99);
    ra = 5'd31; jr = 1'b1;
    #1;
    check("jr_comb_r31", da, 32'd111);
    check("jr_b_registered", db, 32'd99);
    we = 1'b1; wr = 5'd31; wd = 32'd7; rb = 5'd1;
    #1;
    check("jr_fwd_r31", da, 32'd7);
    check("jr_b_unchanged", db, 32'd99);
    step();
    we = 1'b0; jr = 1'b0;
    #1;
    check("jr_off_reg_a", da, 32'd7);
    check("jr_off_b_r1", db, 32'd555);
    jr = 1'b1; ra = 5'd0; we = 1'b1; wr = 5'd0; wd = 32'hFFFF_FFFF;
    #1;
    check("jr_r0_zero", da, 32'd0);
    step();
    jr = 1'b0; we = 1'b0; ra = 5'd1; rb = 5'd10;
    step();
    check("pre_rst_a_r1", da, 32'd555);
    check("pre_rst_b_r10", db, 32'd99);
    rst_n = 1'b0; we = 1'b1; wr = 5'd1; wd = 32'd42;
    step();
    check("midrst_a", da, 32'd0);
    check("midrst_b", db, 32'd0);
    rst_n = 1'b1; we = 1'b0;
    step();
    check("post_rst_a_r1", da, 32'd0);
    check("post_rst_b_r10", db, 32'd0);
    ra = 5'd31; rb = 5'd5;
    step();
    check("post_rst_a_r31", da, 32'd0);
    check("post_rst_b_r5", db, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
